// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read port (AR/R) among N_MASTERS cores, one burst at a time.
// Optional stall watchdog with wdt_err output: define AXI_RD_ARB_WDT_EN.

module axi_rd_arbiter #(
    parameter int N_MASTERS  = 4,
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
`ifdef AXI_RD_ARB_WDT_EN
    parameter int WDT_CYCLES = 256,
`endif
    localparam int AR_W  = ID_WIDTH + ADDR_WIDTH + 13,
    localparam int R_W   = ID_WIDTH + DATA_WIDTH + 1,
    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_MASTERS-1:0]      s_arvalid,
    output logic [N_MASTERS-1:0]      s_arready,
    input  logic [N_MASTERS*AR_W-1:0] s_ar,
    output logic [N_MASTERS-1:0]      s_rvalid,
    input  logic [N_MASTERS-1:0]      s_rready,
    output logic [R_W-1:0]            s_r,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    output logic [AR_W-1:0]           m_ar,
    input  logic                      m_rvalid,
    output logic                      m_rready,
`ifdef AXI_RD_ARB_WDT_EN
    output logic                      wdt_err,
`endif
    input  logic [R_W-1:0]            m_r
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                 state;
    logic [IDX_W-1:0]       grant;
    logic [IDX_W-1:0]       last_grant;
    logic [N_MASTERS-1:0]   grant_oh;
    logic [IDX_W-1:0]       pick;
    logic [IDX_W-1:0]       cand;
    logic                   pick_valid;
    logic [8:0]             beat_cnt;
    logic                   ar_hs;
    logic                   r_hs;
    logic [AR_W-1:0]        s_ar_arr [N_MASTERS];

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_ar_split
        assign s_ar_arr[i] = s_ar[i*AR_W +: AR_W];
    end

    // Round-robin search starting just after the previous winner.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        pick       = '0;
        cand       = '0;
        pick_valid = 1'b0;
        for (int i = 1; i <= N_MASTERS; i++) begin
            cand = IDX_W'((int'(last_grant) + i) % N_MASTERS);
            if (!pick_valid && s_arvalid[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    assign ar_hs     = m_arvalid && m_arready;
    assign r_hs      = m_rvalid && m_rready;
    assign s_arready = ar_hs ? grant_oh : '0;
    assign s_rvalid  = (state == DATA && m_rvalid) ? grant_oh : '0;
    assign m_rready  = (state == DATA) && |(s_rready & grant_oh);
    assign s_r       = (state == DATA) ? m_r : '0;

`ifdef AXI_RD_ARB_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
    logic [WDT_W-1:0] wdt_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IDX_W'(N_MASTERS - 1);
            grant_oh   <= '0;
            m_arvalid  <= 1'b0;
            m_ar       <= '0;
            beat_cnt   <= '0;
`ifdef AXI_RD_ARB_WDT_EN
            wdt_cnt    <= '0;
            wdt_err    <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant           <= pick;
                        grant_oh        <= '0;
                        grant_oh[pick]  <= 1'b1;
                        m_ar            <= s_ar_arr[pick];
                        m_arvalid       <= 1'b1;
                        state           <= ADDR;
                    end
                end
                ADDR: begin
                    if (ar_hs) begin
                        m_arvalid <= 1'b0;
                        beat_cnt  <= '0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (r_hs) begin
                        beat_cnt <= beat_cnt + 9'd1;
                        if (m_r[0]) begin
                            last_grant <= grant;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef AXI_RD_ARB_WDT_EN
            // Any handshake restarts the stall count; expiry abandons the burst.
            wdt_err <= 1'b0;
            if (state == IDLE) begin
                wdt_cnt <= '0;
            end else if (ar_hs || r_hs) begin
                wdt_cnt <= '0;
            end else if (wdt_cnt == WDT_W'(WDT_CYCLES - 1)) begin
                wdt_cnt    <= '0;
                wdt_err    <= 1'b1;
                m_arvalid  <= 1'b0;
                last_grant <= grant;
                state      <= IDLE;
            end else begin
                wdt_cnt <= wdt_cnt + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: RAM-side stimulus, scoreboard of expected R beats per master.
// Watchdog step runs only when AXI_RD_ARB_WDT_EN is defined.

module tb_axi_rd_arbiter;

    localparam int N    = 4;
    localparam int IW   = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int AR_W = IW + AW + 13;
    localparam int R_W  = IW + DW + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      s_arvalid;
    logic [N-1:0]      s_arready;
    logic [N*AR_W-1:0] s_ar;
    logic [N-1:0]      s_rvalid;
    logic [N-1:0]      s_rready;
    logic [R_W-1:0]    s_r;
    logic              m_arvalid;
    logic              m_arready;
    logic [AR_W-1:0]   m_ar;
    logic              m_rvalid;
    logic              m_rready;
    logic [R_W-1:0]    m_r;
`ifdef AXI_RD_ARB_WDT_EN
    logic              wdt_err;
`endif

    int total = 0;
    int bad   = 0;
    int w;
    int n;

    logic [AR_W-1:0]  ar_of [N];
    logic [IW-1:0]    id_of [N];
    logic [N+R_W-1:0] sbq [$];
    logic [N+R_W-1:0] mon_want;

    axi_rd_arbiter #(
`ifdef AXI_RD_ARB_WDT_EN
        .WDT_CYCLES (16),
`endif
        .N_MASTERS  (N),
        .ID_WIDTH   (IW),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_ar      (s_ar),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .s_r       (s_r),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_ar      (m_ar),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
`ifdef AXI_RD_ARB_WDT_EN
        .wdt_err   (wdt_err),
`endif
        .m_r       (m_r)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [N-1:0] oh(input int m);
        oh = N'(1) << m;
    endfunction

    task automatic set_ar(input int m, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input logic [7:0] len);
        ar_of[m] = {id, addr, len, 3'd2, 2'b01};
        id_of[m] = id;
        s_ar[m*AR_W +: AR_W] = ar_of[m];
    endtask

    task automatic reset_dut();
        m_rvalid  = 1'b0;
        m_arready = 1'b0;
        rst_n     = 1'b0;
        #1;
        step();
        rst_n = 1'b1;
        step();
    endtask

    // One full burst for master m as seen from the RAM side.
    task automatic do_burst(input int m, input int len, input int ar_stall, input int st_beat,
                            input int st_len, input int late_m, input bit drop, output int waits);
        waits = 0;
        while (m_arvalid !== 1'b1 && waits < 20) begin
            step();
            waits++;
        end
        check("ar_valid", m_arvalid, 1'b1);
        check("ar_payload", m_ar, ar_of[m]);
        for (int i = 0; i < ar_stall; i++) begin
            s_ar[m*AR_W +: AR_W] = ~ar_of[m];
            m_rvalid = 1'b1;
            m_r      = {4'hF, 32'hDEAD_BEEF, 1'b1};
            #1;
            check("ar_stall_arready", s_arready, '0);
            check("ar_stall_rvalid", s_rvalid, '0);
            check("ar_stall_rready", m_rready, 1'b0);
            check("ar_stall_hold", m_ar, ar_of[m]);
            step();
        end
        s_ar[m*AR_W +: AR_W] = ar_of[m];
        m_rvalid  = 1'b0;
        m_arready = 1'b1;
        #1;
        check("ar_ready", s_arready, oh(m));
        step();
        m_arready = 1'b0;
        if (drop) s_arvalid = s_arvalid & ~oh(m);
        check("ar_done", m_arvalid, 1'b0);
        s_rready = '1;
        for (int b = 0; b <= len; b++) begin
            if (b == 1 && late_m >= 0) s_arvalid = s_arvalid | oh(late_m);
            m_r      = {id_of[m], 32'($urandom()), b == len};
            m_rvalid = 1'b1;
            sbq.push_back({oh(m), m_r});
            for (int s = 0; b == st_beat && s < st_len; s++) begin
                s_rready = ~oh(m);
                #1;
                check("r_stall_rready", m_rready, 1'b0);
                check("r_stall_rvalid", s_rvalid, oh(m));
                step();
            end
            s_rready = '1;
            #1;
            check("r_lock_arready", s_arready, '0);
            step();
        end
        m_rvalid = 1'b0;
        m_r      = '0;
        check("idle_arvalid", m_arvalid, 1'b0);
        check("idle_rready", m_rready, 1'b0);
        check("sb_drained", sbq.size(), 0);
    endtask

    // Scoreboard: every R handshake must match the next expected beat and target master.
    always @(negedge clk) begin
        if (rst_n && m_rvalid && m_rready) begin
            if (sbq.size() == 0) begin
                check("r_extra_beat", {s_rvalid, s_r}, '0);
            end else begin
                mon_want = sbq.pop_front();
                check("r_beat", {s_rvalid, s_r}, mon_want);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: bench did not finish within time limit");
        $fatal(1);
    end

    initial begin
        s_arvalid = '0;
        s_rready  = '1;
        m_arready = 1'b1;
        m_rvalid  = 1'b1;
        m_r       = {4'hA, 32'hCAFE_F00D, 1'b1};
        s_ar      = '0;
        for (int m = 0; m < N; m++) set_ar(m, IW'(m + 1), AW'(32'h1000 * (m + 1)), 8'd0);

        // Reset state with active-looking inputs
        step();
        check("rst_arvalid", m_arvalid, 1'b0);
        check("rst_ar", m_ar, '0);
        check("rst_arready", s_arready, '0);
        check("rst_rvalid", s_rvalid, '0);
        check("rst_rready", m_rready, 1'b0);
        check("rst_r", s_r, '0);
`ifdef AXI_RD_ARB_WDT_EN
        check("rst_wdt", wdt_err, 1'b0);
`endif
        m_rvalid  = 1'b0;
        m_r       = '0;
        m_arready = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // 1: lone master 2, 4-beat burst, one-cycle AR latency
        set_ar(2, 4'h5, 32'h40, 8'd3);
        s_arvalid = oh(2);
        do_burst(2, 3, 0, -1, 0, -1, 1'b1, w);
        check("t1_latency", w, 1);

        // 2: all masters requesting, single beats, grant order 0,1,2,3,0,1 with one bubble
        reset_dut();
        for (int m = 0; m < N; m++) set_ar(m, IW'(m), AW'(32'h200 + m * 16), 8'd0);
        s_arvalid = '1;
        for (int k = 0; k < 6; k++) begin
            do_burst(k % N, 0, 0, -1, 0, -1, 1'b0, w);
            check("t2_bubble", w, 1);
        end
        s_arvalid = '0;

        // 3: AR stall of 5 cycles, then R stall of 3 cycles at beat 1
        set_ar(2, 4'h7, 32'h300, 8'd3);
        s_arvalid = oh(2);
        do_burst(2, 3, 5, 1, 3, -1, 1'b1, w);
        check("t3_latency", w, 1);

        // 4: master 1 requests during master 0's 8-beat burst; granted right after
        set_ar(0, 4'h3, 32'h400, 8'd7);
        set_ar(1, 4'h9, 32'h500, 8'd1);
        s_arvalid = oh(0);
        do_burst(0, 7, 0, -1, 0, 1, 1'b1, w);
        do_burst(1, 1, 0, -1, 0, -1, 1'b1, w);
        check("t4_next_bubble", w, 1);

        // 5: asynchronous reset during beat 2, then masters 0 and 3 arbitrate from fresh state
        set_ar(2, 4'hC, 32'h600, 8'd3);
        s_arvalid = oh(2);
        w = 0;
        while (m_arvalid !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        check("t5_ar", m_ar, ar_of[2]);
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        s_arvalid = '0;
        s_rready  = '1;
        for (int b = 0; b < 2; b++) begin
            m_r      = {id_of[2], 32'($urandom()), 1'b0};
            m_rvalid = 1'b1;
            sbq.push_back({oh(2), m_r});
            step();
        end
        m_r      = {id_of[2], 32'($urandom()), 1'b0};
        m_rvalid = 1'b1;
        #1;
        check("t5_beat2_rvalid", s_rvalid, oh(2));
        set_ar(0, 4'h1, 32'h700, 8'd0);
        set_ar(3, 4'h4, 32'h800, 8'd0);
        s_arvalid = oh(0) | oh(3);
        rst_n = 1'b0;
        #1;
        check("t5_arvalid", m_arvalid, 1'b0);
        check("t5_rready", m_rready, 1'b0);
        check("t5_rvalid", s_rvalid, '0);
        check("t5_arready", s_arready, '0);
        check("t5_r", s_r, '0);
        check("t5_ar_clr", m_ar, '0);
        check("t5_sb", sbq.size(), 0);
        m_rvalid = 1'b0;
        m_r      = '0;
        step();
        step();
        rst_n = 1'b1;
        do_burst(0, 0, 0, -1, 0, -1, 1'b1, w);
        check("t5_first", w, 1);
        do_burst(3, 0, 0, -1, 0, -1, 1'b1, w);
        check("t5_second", w, 1);

`ifdef AXI_RD_ARB_WDT_EN
        // 6: stalled DATA phase trips the watchdog after 16 cycles; master 2 follows master 1
        set_ar(1, 4'h2, 32'h900, 8'd3);
        set_ar(2, 4'h6, 32'hA00, 8'd0);
        s_arvalid = oh(1) | oh(2);
        w = 0;
        while (m_arvalid !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        check("t6_ar", m_ar, ar_of[1]);
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        s_arvalid = oh(2);
        s_rready  = '1;
        n = 0;
        while (wdt_err !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("t6_wdt_cycles", n, 16);
        check("t6_idle_rready", m_rready, 1'b0);
        step();
        check("t6_wdt_pulse", wdt_err, 1'b0);
        check("t6_regrant", m_arvalid, 1'b1);
        check("t6_next", m_ar, ar_of[2]);
        do_burst(2, 0, 0, -1, 0, -1, 1'b1, w);
        check("t6_wdt_quiet", wdt_err, 1'b0);
`endif

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares the single read port (AR/R) of the on-chip AXI RAM among N_MASTERS CPU cores.
- Uses round-robin arbitration and allows one outstanding burst at a time.
- The grant is locked from the AR handshake until the R beat with RLAST set.
- Write-path arbitration is handled by a separate block; this block covers reads only.

Parameters:
N_MASTERS, 4, number of requesting cores (>=2)
ID_WIDTH, 4, ARID/RID width
ADDR_WIDTH, 32, ARADDR width
DATA_WIDTH, 32, RDATA width
WDT_CYCLES, 256, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
s_arvalid  in  N_MASTERS  per-master ARVALID
s_arready  out  N_MASTERS  per-master ARREADY
s_ar  in  N_MASTERS*AR_W  per-master {id,addr,len[7:0],size[2:0],burst[1:0]}; AR_W=ID_WIDTH+ADDR_WIDTH+13; master i occupies slice i
s_rvalid  out  N_MASTERS  per-master RVALID
s_rready  in  N_MASTERS  per-master RREADY
s_r  out  ID_WIDTH+DATA_WIDTH+1  {rid,rdata,rlast}, broadcast to all masters, qualified by s_rvalid
m_arvalid  out  1  ARVALID to the RAM
m_arready  in  1  ARREADY from the RAM
m_ar  out  AR_W  AR payload of the granted master
m_rvalid  in  1  RVALID from the RAM
m_rready  out  1  RREADY to the RAM
m_r  in  ID_WIDTH+DATA_WIDTH+1  {rid,rdata,rlast} from the RAM

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - grant index = 0.
  - RR pointer last_grant = N_MASTERS-1, so master 0 has highest priority after reset.
- Reset is asynchronous and may assert in any state, including mid-burst. Outputs drop to 0 immediately, the burst is abandoned, and there is no handshake completion.
- Index width is max(1,$clog2(N_MASTERS)).
- States: IDLE, ADDR, DATA.
- IDLE:
  - All s_arready, s_rvalid, m_arvalid and m_rready are 0.
  - If any s_arvalid bit is set, select the first set bit searching last_grant+1, last_grant+2, ... modulo N_MASTERS.
  - Register the selection as grant and go to ADDR.
  - Latency: request seen in cycle T gives m_arvalid=1 in cycle T+1.
- ADDR:
  - m_arvalid=1.
  - m_ar = s_ar slice[grant], registered at entry to ADDR. It is held stable until the handshake even if the master changes its inputs (AXI requires them stable anyway).
  - s_arready[grant] = m_arready; all other s_arready bits are 0.
  - On m_arvalid && m_arready, go to DATA.
- DATA:
  - s_rvalid[grant] = m_rvalid; all other s_rvalid bits are 0.
  - m_rready = s_rready[grant].
  - s_r = m_r, passed through combinationally with zero latency.
  - On a handshake with rlast=1: go to IDLE and set last_grant <= grant.
  - A handshake with rlast=0 stays in DATA.
  - A beat counter counts R handshakes for debug visibility only; it does not drive any output.
- Simultaneous events:
  - New requests arriving during ADDR or DATA are ignored until the state returns to IDLE. There is no preemption.
  - Requests present in the cycle the state returns to IDLE are arbitrated in the next IDLE cycle, so there is one idle bubble per burst.
- Starvation: any continuously asserted requester is granted within N_MASTERS bursts.
- m_rvalid while in IDLE or ADDR is ignored: m_rready=0 and no s_rvalid bit is set.

Optional Feature:
- Macro AXI_RD_ARB_WDT_EN.
- When defined:
  - Adds output port wdt_err (1 bit, reset 0).
  - A counter, reset on entry to ADDR or DATA and on every m_arvalid&&m_arready or m_rvalid&&m_rready handshake, increments each cycle spent in ADDR or DATA.
  - When the count reaches WDT_CYCLES: pulse wdt_err for 1 cycle, force the state to IDLE, and set last_grant <= grant.
- When undefined: there is no wdt_err port or counter, and a stalled burst holds the grant indefinitely.

Test Plan:
1. Only master 2 requests, ARLEN=3, addr 0x40 -> m_arvalid=1 one cycle later with m_ar=slice 2; after m_arready, 4 beats appear only on s_rvalid[2]; s_r matches m_r each beat; IDLE follows the rlast beat.
2. All 4 masters hold s_arvalid with ARLEN=0 -> grant order 0,1,2,3,0,1, with exactly one bubble cycle between bursts.
3. m_arready=0 for 5 cycles, then s_rready[g]=0 for 3 cycles mid-burst -> m_ar stable and s_arready all 0 during the first stall; m_rready=0 during the second stall; no beats are lost or duplicated.
4. Master 1 asserts s_arvalid during master 0's 8-beat burst -> s_arready[1] stays 0 until after master 0's rlast; master 1 is granted next.
5. rst_n asserted low during beat 2 of a burst -> all outputs 0 asynchronously; after release, a request from masters 0 and 3 grants master 0 first.
6. With AXI_RD_ARB_WDT_EN and WDT_CYCLES=16, m_rvalid held 0 in DATA -> wdt_err=1 for exactly one cycle after 16 stalled cycles, state returns to IDLE, and the next requester in RR order is granted.
